// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start detect, mid-bit baud timing and shift sequencing for a 12-bit UART RX datapath.
// Short formats are padded with forced-1 shifts so every frame lands in the same register layout.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic par_en,
    input  logic par_odd,
    input  logic two_stop,
    input  logic rx_in,
    input  logic valid_in,
    input  logic parity_ok,
    input  logic stop_ok,
    output logic rx_sel,
    output logic rx_sr_en,
    output logic parity_sel,
    output logic stop_sel,
    output logic busy,
    output logic rx_done,
    output logic parity_err,
    output logic frame_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2, CHECK} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0] bit_idx;
    logic cfg_par, start, full, half;
    assign start = (state == IDLE) && en && valid_in;
    assign full  = cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign half  = cnt == CNT_W'(HALF_BIT - 1);
    assign busy  = state != IDLE;
    always_comb begin
        state_nx = state;
        rx_sel   = 1'b1;
        rx_sr_en = 1'b0;
        rx_done  = 1'b0;
        case (state)
            IDLE:  state_nx = start ? START : IDLE;
            START: if (half) begin
                rx_sr_en = !rx_in;
                state_nx = rx_in ? IDLE : DATA;
            end
            DATA:  if (full) begin
                rx_sr_en = 1'b1;
                state_nx = (bit_idx == 3'd7) ? PAR : DATA;
            end
            PAR:   if (!cfg_par || full) begin
                rx_sel   = cfg_par;
                rx_sr_en = 1'b1;
                state_nx = STOP1;
            end
            STOP1: if (full) begin
                rx_sr_en = 1'b1;
                state_nx = STOP2;
            end
            STOP2: if (!stop_sel || full) begin
                rx_sel   = stop_sel;
                rx_sr_en = 1'b1;
                state_nx = CHECK;
            end
            CHECK: begin
                rx_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // pad shifts leave cnt running so the next line sample stays one bit time after the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            cfg_par    <= 1'b0;
            parity_sel <= 1'b0;
            stop_sel   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= (state == IDLE || (rx_sr_en && rx_sel)) ? '0 : cnt + 1'b1;
            bit_idx <= (state == START) ? 3'd0 : (state == DATA && rx_sr_en) ? bit_idx + 3'd1 : bit_idx;
            if (start) begin
                cfg_par    <= par_en;
                parity_sel <= par_odd;
                stop_sel   <= two_stop;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
            if (state == CHECK) begin
                parity_err <= cfg_par & ~parity_ok;
                frame_err  <= ~stop_ok;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: serial frame stimulus with a shift-register datapath model and an expected-frame queue.
module tb_uart_rx_ctrl;
    localparam int CPB = 16;
    typedef struct packed {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        logic [11:0] pads;
        logic        psel;
        logic        ssel;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0, rx_in = 1'b1;
    logic prev_rx, valid_in, parity_ok, stop_ok;
    logic rx_sel, rx_sr_en, parity_sel, stop_sel, busy, rx_done, parity_err, frame_err;
    logic [11:0] sr = '0, pads = '0;
    int checks = 0, failures = 0, n_sh = 0, n_done = 0;
    logic pend = 1'b0;
    exp_t q[$];
    exp_t cur;
    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .en(en), .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop),
        .rx_in(rx_in), .valid_in(valid_in), .parity_ok(parity_ok), .stop_ok(stop_ok),
        .rx_sel(rx_sel), .rx_sr_en(rx_sr_en), .parity_sel(parity_sel), .stop_sel(stop_sel),
        .busy(busy), .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) prev_rx <= reset ? 1'b1 : rx_in;
    assign valid_in  = prev_rx & ~rx_in;
    assign parity_ok = (^sr[9:1]) == parity_sel;
    assign stop_ok   = sr[10] & sr[11];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // datapath model and scoreboard consumer
    always @(negedge clk) begin
        if (reset) begin
            n_sh = 0;
            pads = '0;
            pend = 1'b0;
        end else begin
            if (rx_sr_en) begin
                if (!rx_sel && n_sh < 12) pads[n_sh] = 1'b1;
                sr = {rx_sel ? rx_in : 1'b1, sr[11:1]};
                n_sh++;
            end
            if (pend) begin
                check("parity_err", parity_err, cur.perr);
                check("frame_err", frame_err, cur.ferr);
                pend = 1'b0;
            end
            if (rx_done) begin
                n_done++;
                check("done_vs_shift", rx_sr_en, 0);
                if (q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    cur = q.pop_front();
                    check("data", sr[8:1], cur.data);
                    check("shift_count", n_sh, 12);
                    check("pad_mask", pads, cur.pads);
                    check("parity_sel", parity_sel, cur.psel);
                    check("stop_sel", stop_sel, cur.ssel);
                    pend = 1'b1;
                end
                n_sh = 0;
                pads = '0;
            end
        end
    end
    task automatic bit_out(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                              input logic bad_par, input logic bad_stop);
        exp_t e;
        e = '{d, pe & bad_par, bad_stop, {~ts, 1'b0, ~pe, 9'b0}, po, ts};
        q.push_back(e);
        en = 1'b1; par_en = pe; par_odd = po; two_stop = ts;
        bit_out(1'b0);
        en = 1'b0; par_en = ~pe; par_odd = ~po; two_stop = ~ts;
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (pe) bit_out(^d ^ po ^ bad_par);
        bit_out(~bad_stop);
        if (ts) bit_out(1'b1);
        en = 1'b1; par_en = pe; par_odd = po; two_stop = ts;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clk);
        check("done_timeout", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask
    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask
    int d0;
    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_sel", rx_sel, 1);
        check("rst_sr_en", rx_sr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", rx_done, 0);
        check("rst_errs", {parity_err, frame_err}, 0);
        check("rst_sels", {parity_sel, stop_sel}, 0);
        @(posedge clk); #1 reset = 1'b0;
        idle(4);
        send_frame(8'h55, 1, 0, 0, 0, 0);
        wait_done();
        d0 = n_done;
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("glitch_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (CPB) @(posedge clk);
        #1 check("glitch_idle", busy, 0);
        check("glitch_shifts", n_sh, 0);
        check("glitch_done", n_done, d0);
        en = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("en_off_busy", busy, 0);
        idle(4);
        send_frame(8'hA3, 1, 1, 0, 1, 0);
        wait_done();
        send_frame(8'h0F, 0, 0, 1, 0, 1);
        wait_done();
        send_frame(8'hFF, 0, 0, 1, 0, 0);
        wait_done();
        send_frame(8'h81, 1, 1, 1, 0, 0);
        send_frame(8'h7E, 0, 0, 0, 0, 1);
        wait_done();
        d0 = n_done;
        par_odd = 1'b1; par_en = 1'b1;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(i[0]);
        rx_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1 check("arst_busy", busy, 0);
        check("arst_sr_en", rx_sr_en, 0);
        check("arst_rx_sel", rx_sel, 1);
        check("arst_done", rx_done, 0);
        check("arst_errs", {parity_err, frame_err}, 0);
        check("arst_sels", {parity_sel, stop_sel}, 0);
        @(posedge clk); #1 reset = 1'b0;
        idle(3 * CPB);
        check("arst_no_done", n_done, d0);
        send_frame(8'h3C, 1, 0, 0, 0, 0);
        wait_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
